// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the byte-wide memory bus interconnect.
package mem_bus_pkg;

   typedef enum logic {
      REGION_RAM = 1'b0,
      REGION_IO  = 1'b1
   } region_e;

   localparam logic [1:0]  IO_PREFIX      = 2'b11;
   localparam int unsigned ARB_FIXED      = 0;
   localparam int unsigned ARB_RR         = 1;
   localparam int unsigned MAX_ADDR_WIDTH = 64;

   // Region decode: the two bits straddling the RAM address MSB select I/O when both set.
   function automatic region_e region_of(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                         input int unsigned               ram_addr_width);
      logic [1:0] prefix;
      prefix = 2'(addr >> (ram_addr_width - 1));
      return (prefix == IO_PREFIX) ? REGION_IO : REGION_RAM;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Grant selector: fixed priority or round robin, restricted to the lock owner while a lock is held.
module bus_rr_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned ARB_MODE    = ARB_FIXED,
   localparam int unsigned IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic [NUM_MASTERS-1:0] eligible,
   input  logic [IDX_W-1:0]       rr_ptr,
   input  logic                   lock_active,
   input  logic [IDX_W-1:0]       lock_owner,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   gnt_valid,
   output logic [IDX_W-1:0]       gnt_idx
);

   logic [NUM_MASTERS-1:0] masked;
   int                     cand;

   // Pick one winner among the eligible (and lock-permitted) masters.
   always_comb begin
      masked    = eligible;
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      if (lock_active) begin
         masked = eligible & (NUM_MASTERS'(1) << lock_owner);
      end
      if (ARB_MODE == ARB_FIXED) begin
         // Descending scan so the lowest index is the last (winning) assignment.
         for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
            if (masked[IDX_W'(i)]) begin
               gnt_valid = 1'b1;
               gnt_idx   = IDX_W'(i);
            end
         end
      end else begin
         // Descending distance from rr_ptr so the nearest successor wins.
         for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
            cand = (int'(rr_ptr) + k) % int'(NUM_MASTERS);
            if (masked[IDX_W'(cand)]) begin
               gnt_valid = 1'b1;
               gnt_idx   = IDX_W'(cand);
            end
         end
      end
      if (gnt_valid) begin
         gnt = NUM_MASTERS'(1) << gnt_idx;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master byte bus interconnect to internal RAM and memory-mapped I/O with one-cycle read return.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned IO_SEL_WIDTH   = 3,
   parameter int unsigned ARB_MODE       = ARB_FIXED
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [NUM_MASTERS-1:0]            m_req_in,
   input  logic [NUM_MASTERS-1:0]            m_wr_in,
   input  logic [NUM_MASTERS-1:0]            m_lock_in,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout_in,
   output logic [NUM_MASTERS-1:0]            m_gnt_out,
   output logic [NUM_MASTERS-1:0]            m_rvalid_out,
   output logic [DATA_WIDTH-1:0]             m_din_out,
   output logic                              ram_en_out,
   output logic                              ram_r_nw_out,
   output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
   output logic [DATA_WIDTH-1:0]             ram_d_out,
   input  logic [DATA_WIDTH-1:0]             ram_d_in,
   output logic                              io_en_out,
   output logic                              io_wr_out,
   output logic [IO_SEL_WIDTH-1:0]           io_sel_out,
   output logic [DATA_WIDTH-1:0]             io_d_out,
   input  logic [DATA_WIDTH-1:0]             io_d_in,
   input  logic                              io_full_in
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] gnt;
   logic                   gnt_valid;
   logic [IDX_W-1:0]       gnt_idx;
   logic                   lock_active;

   logic [IDX_W-1:0]       rr_ptr_q;
   logic                   lock_valid_q, lock_valid_d;
   logic [IDX_W-1:0]       lock_owner_q, lock_owner_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [IDX_W-1:0]       rd_idx_q;
   region_e                rd_region_q;

   logic [ADDR_WIDTH-1:0]  sel_a;
   logic [DATA_WIDTH-1:0]  sel_d;
   logic                   sel_wr;
   region_e                sel_region;

   // A master is eligible unless it is an I/O write while the I/O buffer is full.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         eligible[i] = m_req_in[i] &
                       ~(m_wr_in[i] & io_full_in &
                         (region_of(MAX_ADDR_WIDTH'(m_a_in[i*ADDR_WIDTH +: ADDR_WIDTH]),
                                    RAM_ADDR_WIDTH) == REGION_IO));
      end
   end

   assign lock_active = lock_valid_q & m_lock_in[lock_owner_q];

   bus_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .ARB_MODE    (ARB_MODE)
   ) u_arb (
      .eligible    (eligible),
      .rr_ptr      (rr_ptr_q),
      .lock_active (lock_active),
      .lock_owner  (lock_owner_q),
      .gnt         (gnt),
      .gnt_valid   (gnt_valid),
      .gnt_idx     (gnt_idx)
   );

   // Route the winning master's request fields.
   always_comb begin
      sel_a      = m_a_in[32'(gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];
      sel_d      = m_dout_in[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
      sel_wr     = m_wr_in[gnt_idx];
      sel_region = region_of(MAX_ADDR_WIDTH'(sel_a), RAM_ADDR_WIDTH);
   end

   // Same-cycle grant and target strobes; held at idle values while in reset.
   always_comb begin
      m_gnt_out    = '0;
      ram_en_out   = 1'b0;
      ram_r_nw_out = 1'b1;
      ram_a_out    = '0;
      ram_d_out    = '0;
      io_en_out    = 1'b0;
      io_wr_out    = 1'b0;
      io_sel_out   = '0;
      io_d_out     = '0;
      if (gnt_valid && !rst_in) begin
         m_gnt_out = gnt;
         if (sel_region == REGION_IO) begin
            io_en_out  = 1'b1;
            io_wr_out  = sel_wr;
            io_sel_out = sel_a[IO_SEL_WIDTH-1:0];
            io_d_out   = sel_d;
         end else begin
            ram_en_out   = 1'b1;
            ram_r_nw_out = ~sel_wr;
            ram_a_out    = sel_a[RAM_ADDR_WIDTH-1:0];
            ram_d_out    = sel_d;
         end
      end
   end

   // Read return: data muxed by the region captured at grant, so regions never mix.
   always_comb begin
      m_rvalid_out = '0;
      m_din_out    = '0;
      if (rd_valid_q && !rst_in) begin
         m_rvalid_out = NUM_MASTERS'(1) << rd_idx_q;
         m_din_out    = (rd_region_q == REGION_IO) ? io_d_in : ram_d_in;
      end
   end

   // Next lock ownership and read-return valid.
   always_comb begin
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      rd_valid_d   = gnt_valid & ~sel_wr;
      if (lock_valid_q && !m_lock_in[lock_owner_q]) begin
         lock_valid_d = 1'b0;
      end
      if (gnt_valid && m_lock_in[gnt_idx]) begin
         lock_valid_d = 1'b1;
         lock_owner_d = gnt_idx;
      end
   end

   // State registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr_q     <= IDX_W'(NUM_MASTERS - 1);
         lock_valid_q <= 1'b0;
         lock_owner_q <= '0;
         rd_valid_q   <= 1'b0;
         rd_idx_q     <= '0;
         rd_region_q  <= REGION_RAM;
      end else begin
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         rd_valid_q   <= rd_valid_d;
         if (gnt_valid) begin
            rr_ptr_q    <= gnt_idx;
            rd_idx_q    <= gnt_idx;
            rd_region_q <= sel_region;
         end
      end
   end

endmodule
